toggle_handshake_rx: RTL and testbench

- Receiving end of the team's two-phase toggle handshake.
- The sender flips `req_t` once per event, using the team's toggle flip-flop.
- This block synchronises `req_t`, turns each transition into one queued event and presents events on a valid/ready interface.
- When the consumer accepts an event, the block flips `ack_t` back toward the sender.
- Use it wherever a toggle-encoded event line from another domain or a slow/unregistered source must become clean, counted events.

---
 rtl/toggle_handshake_rx.sv | 77 +++++++
 tb/tb_toggle_handshake_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_rx.sv
// Receiver for the two-phase toggle handshake: synchronises req_t, counts each
// transition as a queued event, serves events on valid/ready and toggles ack_t per take.
module toggle_handshake_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_t,
    output logic             ack_t,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_pending,
    output logic             ovf,
    input  logic             clr_ovf
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_prev_q, req_prev_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   ovf_q, ovf_d;

    logic sync_out;
    logic evt_in;
    logic take;
    logic full;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign evt_in   = sync_out ^ req_prev_q;
    assign take     = (cnt_q != '0) && evt_ready;
    assign full     = (cnt_q == '1);

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], req_t};
        req_prev_d = sync_out;
        ack_d      = ack_q ^ take;

        cnt_d = cnt_q;
        if (evt_in && !take && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (take && !evt_in) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // A same-cycle drop outranks the clear so the loss is never hidden.
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (evt_in && full && !take) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            req_prev_q <= 1'b0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            req_prev_q <= req_prev_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ack_t       = ack_q;
    assign ovf         = ovf_q;
    assign evt_pending = cnt_q;
    assign evt_valid   = (cnt_q != '0);

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Directed bench for toggle_handshake_rx: a vector table for single-event latency and
// concurrent in/out, plus hand sequences for reset, burst/drain, overflow and mid-stream reset.
module tb_toggle_handshake_rx;

    logic       clk;
    logic       rst;
    logic       req_t;
    logic       ack_t;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_pending;
    logic       ovf;
    logic       clr_ovf;

    int checks;
    int failures;

    toggle_handshake_rx #(.SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_t      (req_t),
        .ack_t      (ack_t),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_pending(evt_pending),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic req;
        logic rdy;
        logic clr;
        int   pend;
        logic valid;
        logic ack;
        logic ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int pend, input int valid,
                           input int ack, input int ov);
        chk({tag, ".pending"}, int'(evt_pending), pend);
        chk({tag, ".valid"},   int'(evt_valid),   valid);
        chk({tag, ".ack"},     int'(ack_t),       ack);
        chk({tag, ".ovf"},     int'(ovf),         ov);
    endtask

    task automatic toggle_wait3();
        req_t = ~req_t;
        repeat (3) tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        req_t     = 1'b0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset then idle
        repeat (3) tick();
        chk_all("in_reset", 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle", 0, 0, 0, 0);
        end

        // Single event latency, then pending=2 with a take coinciding with evt_in
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0}; // E0
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0}; // E1
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0}; // E2: counted
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0}; // take
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0}; // take
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0}; // take + evt_in: hold
        vecs[14] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0}; // take
        vecs[15] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0}; // ready ignored
        for (int i = 0; i < 16; i++) begin
            req_t     = vecs[i].req;
            evt_ready = vecs[i].rdy;
            clr_ovf   = vecs[i].clr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].pend, int'(vecs[i].valid),
                    int'(vecs[i].ack), int'(vecs[i].ovf));
        end

        // Burst of 5, then drain
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) toggle_wait3();
        chk_all("burst", 5, 1, 0, 0);
        evt_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk("drain.pending", int'(evt_pending), i);
            chk("drain.ack", int'(ack_t), (i % 2 == 0) ? 1 : 0);
        end
        chk("drain.valid", int'(evt_valid), 0);
        evt_ready = 1'b0;

        // Overflow with 4-bit counter
        for (int i = 0; i < 15; i++) toggle_wait3();
        chk_all("full15", 15, 1, 1, 0);
        toggle_wait3();
        chk_all("ovf16", 15, 1, 1, 1);
        req_t = ~req_t;
        repeat (2) tick();
        clr_ovf = 1'b1;
        tick();
        chk_all("ovf17_set_wins", 15, 1, 1, 1);
        clr_ovf = 1'b0;
        tick();
        chk("ovf_hold", int'(ovf), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk_all("ovf_clear", 15, 1, 1, 0);

        // Reset mid-stream: build pending=3, ack=1
        rst = 1'b0;
        #2;
        chk_all("rst_sync", 0, 0, 0, 0);
        chk("rst_req_low", int'(req_t), 0);
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) toggle_wait3();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk_all("pre_rst", 3, 1, 1, 0);
        #3;
        rst = 1'b0;
        #1;
        chk_all("rst_async", 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst.pending", int'(evt_pending), 0);
            chk("post_rst.ack", int'(ack_t), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
